// File: rtl/cva6_config_pkg.sv
// Core-wide configuration knobs consumed as parameter defaults by the
// write-through store buffer.
package cva6_config_pkg;

    localparam int unsigned CVA6ConfigXlen              = 64;
    localparam int unsigned CVA6ConfigWtDcacheWbufDepth = 8;
    localparam int unsigned CVA6ConfigWbufMergeEn       = 1;

endpackage

// File: rtl/wt_store_wbuf_pkg.sv
// Shared constants and helpers for the write-through store buffer.
package wt_store_wbuf_pkg;

    localparam int unsigned BYTE_W = 8;

    // Occupancy counter must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wt_store_wbuf_if.sv
// Store / memory / load-hazard bundle of the store buffer; master is the
// agent issuing stores and granting memory, slave is the buffer itself.
interface wt_store_wbuf_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned PADDR_W = 56
);
    import wt_store_wbuf_pkg::*;

    localparam int unsigned BE_W = XLEN / BYTE_W;

    logic               st_valid;
    logic               st_ready;
    logic [PADDR_W-1:0] st_paddr;
    logic [XLEN-1:0]    st_data;
    logic [BE_W-1:0]    st_be;
    logic               mem_req;
    logic               mem_gnt;
    logic [PADDR_W-1:0] mem_paddr;
    logic [XLEN-1:0]    mem_data;
    logic [BE_W-1:0]    mem_be;
    logic [PADDR_W-1:0] ld_paddr;
    logic               ld_hit;
    logic               empty;
    logic               full;

    modport master (
        output st_valid, st_paddr, st_data, st_be, mem_gnt, ld_paddr,
        input  st_ready, mem_req, mem_paddr, mem_data, mem_be, ld_hit, empty, full
    );

    modport slave (
        input  st_valid, st_paddr, st_data, st_be, mem_gnt, ld_paddr,
        output st_ready, mem_req, mem_paddr, mem_data, mem_be, ld_hit, empty, full
    );

endinterface

// File: rtl/wt_store_wbuf_match.sv
// Tag compare across all entries plus selection of the youngest matching
// entry, age being measured backwards from the tail pointer.
module wbuf_match
    import wt_store_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 53,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]            key,
    input  logic [PTR_W-1:0]            tail,
    output logic                        hit,
    output logic [PTR_W-1:0]            idx
);

    logic [DEPTH-1:0] eq;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign eq[i] = valid[i] && (tags[i] == key);
    end

    // Walk oldest -> youngest so the youngest match is the last one written.
    always_comb begin
        hit = |eq;
        idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (eq[tail - PTR_W'(k)]) idx = tail - PTR_W'(k);
        end
    end

endmodule

// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: circular FIFO of word-aligned stores with
// byte merging into pending (not yet offered) entries and load hazard lookup.
module wt_store_wbuf
    import wt_store_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH    = cva6_config_pkg::CVA6ConfigWtDcacheWbufDepth,
    parameter int unsigned XLEN     = cva6_config_pkg::CVA6ConfigXlen,
    parameter int unsigned PADDR_W  = 56,
    parameter int unsigned MERGE_EN = cva6_config_pkg::CVA6ConfigWbufMergeEn
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   st_valid_i,
    output logic                   st_ready_o,
    input  logic [PADDR_W-1:0]     st_paddr_i,
    input  logic [XLEN-1:0]        st_data_i,
    input  logic [XLEN/BYTE_W-1:0] st_be_i,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [PADDR_W-1:0]     mem_paddr_o,
    output logic [XLEN-1:0]        mem_data_o,
    output logic [XLEN/BYTE_W-1:0] mem_be_o,
    input  logic [PADDR_W-1:0]     ld_paddr_i,
    output logic                   ld_hit_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned BE_W  = XLEN / BYTE_W;
    localparam int unsigned OFF   = $clog2(BE_W);
    localparam int unsigned TAG_W = PADDR_W - OFF;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic [BE_W-1:0]  be;
    } entry_t;

    entry_t                    ent_q [DEPTH];
    logic [DEPTH-1:0]          vld_q;
    logic [PTR_W-1:0]          head_q, tail_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [DEPTH-1:0][TAG_W-1:0] tags;
    logic [TAG_W-1:0]          st_tag, ld_tag;
    logic                      st_hit, merge_hit, st_acc, alloc, gnt;
    logic [PTR_W-1:0]          st_idx, ld_idx_unused;
    logic [2*OFF-1:0]          addr_lo_unused;

    assign st_tag         = st_paddr_i[PADDR_W-1:OFF];
    assign ld_tag         = ld_paddr_i[PADDR_W-1:OFF];
    assign addr_lo_unused = {st_paddr_i[OFF-1:0], ld_paddr_i[OFF-1:0]};

    for (genvar i = 0; i < DEPTH; i++) begin : g_tags
        assign tags[i] = ent_q[i].tag;
    end

    wbuf_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_st_match (
        .valid (vld_q),
        .tags  (tags),
        .key   (st_tag),
        .tail  (tail_q),
        .hit   (st_hit),
        .idx   (st_idx)
    );

    wbuf_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ld_match (
        .valid (vld_q),
        .tags  (tags),
        .key   (ld_tag),
        .tail  (tail_q),
        .hit   (ld_hit_o),
        .idx   (ld_idx_unused)
    );

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign mem_req_o   = !empty_o;
    assign mem_paddr_o = {ent_q[head_q].tag, {OFF{1'b0}}};
    assign mem_data_o  = ent_q[head_q].data;
    assign mem_be_o    = ent_q[head_q].be;

    // The head is always the offered entry while non-empty, so a youngest
    // match sitting on the head must not merge; the store allocates instead.
    assign merge_hit  = (MERGE_EN != 0) && st_valid_i && st_hit && (st_idx != head_q);
    assign st_ready_o = merge_hit || !full_o;
    assign st_acc     = st_valid_i && st_ready_o;
    assign alloc      = st_acc && !merge_hit;
    assign gnt        = mem_gnt_i && mem_req_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (gnt) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            if (alloc) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(alloc) - CNT_W'(gnt);
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            ent_q[tail_q] <= '{tag: st_tag, data: st_data_i, be: st_be_i};
        end else if (merge_hit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (st_be_i[b]) ent_q[st_idx].data[b*BYTE_W +: BYTE_W] <= st_data_i[b*BYTE_W +: BYTE_W];
            end
            ent_q[st_idx].be <= ent_q[st_idx].be | st_be_i;
        end
    end

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Self-checking bench for wt_store_wbuf: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a queue-based model.
module tb_wt_store_wbuf;

    logic clk = 1'b0;
    logic rst, rst2;
    int   nerr = 0;
    int   nchk = 0;

    always #5 clk = ~clk;

    wt_store_wbuf_if #(.XLEN(64), .PADDR_W(56)) bus ();
    wt_store_wbuf_if #(.XLEN(64), .PADDR_W(56)) bus2 ();

    wt_store_wbuf #(.DEPTH(8), .XLEN(64), .PADDR_W(56), .MERGE_EN(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .st_valid_i(bus.st_valid), .st_ready_o(bus.st_ready), .st_paddr_i(bus.st_paddr),
        .st_data_i(bus.st_data), .st_be_i(bus.st_be),
        .mem_req_o(bus.mem_req), .mem_gnt_i(bus.mem_gnt), .mem_paddr_o(bus.mem_paddr),
        .mem_data_o(bus.mem_data), .mem_be_o(bus.mem_be),
        .ld_paddr_i(bus.ld_paddr), .ld_hit_o(bus.ld_hit),
        .empty_o(bus.empty), .full_o(bus.full)
    );

    wt_store_wbuf #(.DEPTH(8), .XLEN(64), .PADDR_W(56), .MERGE_EN(0)) dut_nm (
        .clk_i(clk), .rst_i(rst2),
        .st_valid_i(bus2.st_valid), .st_ready_o(bus2.st_ready), .st_paddr_i(bus2.st_paddr),
        .st_data_i(bus2.st_data), .st_be_i(bus2.st_be),
        .mem_req_o(bus2.mem_req), .mem_gnt_i(bus2.mem_gnt), .mem_paddr_o(bus2.mem_paddr),
        .mem_data_o(bus2.mem_data), .mem_be_o(bus2.mem_be),
        .ld_paddr_i(bus2.ld_paddr), .ld_hit_o(bus2.ld_hit),
        .empty_o(bus2.empty), .full_o(bus2.full)
    );

    typedef struct {
        logic        sv;
        logic [55:0] pa;
        logic [63:0] d;
        logic [7:0]  be;
        logic        gnt;
        logic [55:0] la;
        logic        e_rdy;
        logic        e_req;
        logic [55:0] e_pa;
        logic [63:0] e_d;
        logic [7:0]  e_be;
        logic        e_ld;
        logic        e_empty;
        logic        e_full;
        logic        chk_d;
    } vec_t;

    typedef struct {
        logic [52:0] tag;
        logic [63:0] data;
        logic [7:0]  be;
    } ment_t;

    vec_t  vt [16];
    ment_t mq [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic sv, input logic [55:0] pa, input logic [63:0] d, input logic [7:0] be,
        input logic gnt, input logic [55:0] la,
        input logic e_rdy, input logic e_req, input logic [55:0] e_pa, input logic [63:0] e_d,
        input logic [7:0] e_be, input logic e_ld, input logic e_empty, input logic e_full,
        input logic chk_d);
        vec_t v;
        v.sv = sv; v.pa = pa; v.d = d; v.be = be; v.gnt = gnt; v.la = la;
        v.e_rdy = e_rdy; v.e_req = e_req; v.e_pa = e_pa; v.e_d = e_d; v.e_be = e_be;
        v.e_ld = e_ld; v.e_empty = e_empty; v.e_full = e_full; v.chk_d = chk_d;
        return v;
    endfunction

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m = '0;
        for (int b = 0; b < 8; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic drive(input logic sv, input logic [55:0] pa, input logic [63:0] d,
                         input logic [7:0] be, input logic gnt, input logic [55:0] la);
        bus.st_valid = sv; bus.st_paddr = pa; bus.st_data = d; bus.st_be = be;
        bus.mem_gnt = gnt; bus.ld_paddr = la;
    endtask

    task automatic drive2(input logic sv, input logic [55:0] pa, input logic [63:0] d,
                          input logic [7:0] be, input logic gnt, input logic [55:0] la);
        bus2.st_valid = sv; bus2.st_paddr = pa; bus2.st_data = d; bus2.st_be = be;
        bus2.mem_gnt = gnt; bus2.ld_paddr = la;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [55:0] exp_pa;
        logic [63:0] exp_d;
        logic [7:0]  exp_be;

        // sv pa d be gnt la | rdy req e_pa e_d e_be ld empty full chk_d
        vt[0]  = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 56'h1000,
                     1'b1, 1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[1]  = mkv(1'b1, 56'h1000, 64'h11,                 8'h01, 1'b0, 56'h1000,
                     1'b1, 1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[2]  = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 56'h1000,
                     1'b1, 1'b1, 56'h1000, 64'h11,                 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[3]  = mkv(1'b1, 56'h1000, 64'h2200,               8'h02, 1'b0, 56'h1008,
                     1'b1, 1'b1, 56'h1000, 64'h11,                 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[4]  = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 56'h1000,
                     1'b1, 1'b1, 56'h1000, 64'h11,                 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[5]  = mkv(1'b1, 56'h1000, 64'h440000,             8'h04, 1'b0, 56'h1000,
                     1'b1, 1'b1, 56'h1000, 64'h11,                 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[6]  = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b1, 56'h1000,
                     1'b1, 1'b1, 56'h1000, 64'h11,                 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[7]  = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 56'h1000,
                     1'b1, 1'b1, 56'h1000, 64'h442200,             8'h06, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[8]  = mkv(1'b1, 56'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 56'h1000,
                     1'b1, 1'b1, 56'h1000, 64'h442200,             8'h06, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[9]  = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 56'h1000,
                     1'b1, 1'b1, 56'h1000, 64'h0,                  8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[10] = mkv(1'b1, 56'h2000, 64'hAABB_CCDD,          8'h0F, 1'b0, 56'h2000,
                     1'b1, 1'b1, 56'h1000, 64'h0,                  8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[11] = mkv(1'b1, 56'h2004, 64'h1122_3344_0000_0000, 8'hF0, 1'b0, 56'h2000,
                     1'b1, 1'b1, 56'h1000, 64'h0,                  8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[12] = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b1, 56'h2000,
                     1'b1, 1'b1, 56'h1000, 64'h0,                  8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[13] = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b1, 56'h2000,
                     1'b1, 1'b1, 56'h2000, 64'h1122_3344_AABB_CCDD, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[14] = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b1, 56'h2000,
                     1'b1, 1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[15] = mkv(1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 56'h2000,
                     1'b1, 1'b0, 56'h0,    64'h0,                  8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // ---- reset state ----
        rst = 1'b1; rst2 = 1'b1;
        drive(1'b0, 56'h0, 64'h0, 8'h00, 1'b0, 56'h1000);
        drive2(1'b0, 56'h0, 64'h0, 8'h00, 1'b0, 56'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", {63'h0, bus.empty}, 64'h1);
        chk("rst_full", {63'h0, bus.full}, 64'h0);
        chk("rst_req", {63'h0, bus.mem_req}, 64'h0);
        chk("rst_ldhit", {63'h0, bus.ld_hit}, 64'h0);
        rst = 1'b0; rst2 = 1'b0;

        // ---- directed vector table ----
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].sv, vt[i].pa, vt[i].d, vt[i].be, vt[i].gnt, vt[i].la);
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), {63'h0, bus.st_ready}, {63'h0, vt[i].e_rdy});
            chk($sformatf("v%0d_req", i), {63'h0, bus.mem_req}, {63'h0, vt[i].e_req});
            chk($sformatf("v%0d_ldhit", i), {63'h0, bus.ld_hit}, {63'h0, vt[i].e_ld});
            chk($sformatf("v%0d_empty", i), {63'h0, bus.empty}, {63'h0, vt[i].e_empty});
            chk($sformatf("v%0d_full", i), {63'h0, bus.full}, {63'h0, vt[i].e_full});
            if (vt[i].e_req) begin
                chk($sformatf("v%0d_paddr", i), {8'h0, bus.mem_paddr}, {8'h0, vt[i].e_pa});
                chk($sformatf("v%0d_be", i), {56'h0, bus.mem_be}, {56'h0, vt[i].e_be});
            end
            if (vt[i].chk_d) chk($sformatf("v%0d_data", i), bus.mem_data, vt[i].e_d);
            next_cycle();
        end

        // ---- fill across pointer wrap, full-buffer behaviour, drain order ----
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 56'h10000 + 56'(i * 8), 64'(i), 8'h01, 1'b0, 56'h0);
            @(negedge clk);
            chk($sformatf("fill%0d_rdy", i), {63'h0, bus.st_ready}, 64'h1);
            next_cycle();
        end
        drive(1'b1, 56'h20000, 64'h0, 8'h01, 1'b0, 56'h0);
        @(negedge clk);
        chk("full_flag", {63'h0, bus.full}, 64'h1);
        chk("full_newtag_rdy", {63'h0, bus.st_ready}, 64'h0);
        next_cycle();
        drive(1'b1, 56'h10018, 64'hAB00, 8'h02, 1'b0, 56'h0);
        @(negedge clk);
        chk("full_merge_rdy", {63'h0, bus.st_ready}, 64'h1);
        next_cycle();
        drive(1'b1, 56'h30000, 64'h33, 8'h01, 1'b1, 56'h0);
        @(negedge clk);
        chk("full_gnt_rdy", {63'h0, bus.st_ready}, 64'h0);
        chk("full_gnt_head", {8'h0, bus.mem_paddr}, 64'h10000);
        next_cycle();
        drive(1'b1, 56'h30000, 64'h33, 8'h01, 1'b0, 56'h0);
        @(negedge clk);
        chk("after_gnt_rdy", {63'h0, bus.st_ready}, 64'h1);
        chk("after_gnt_full", {63'h0, bus.full}, 64'h0);
        next_cycle();
        drive(1'b0, 56'h0, 64'h0, 8'h00, 1'b0, 56'h0);
        @(negedge clk);
        chk("refill_full", {63'h0, bus.full}, 64'h1);
        next_cycle();
        for (int k = 1; k <= 8; k++) begin
            exp_pa = (k == 8) ? 56'h30000 : 56'h10000 + 56'(k * 8);
            exp_d  = (k == 8) ? 64'h33 : (k == 3) ? 64'hAB03 : 64'(k);
            exp_be = (k == 3) ? 8'h03 : 8'h01;
            drive(1'b0, 56'h0, 64'h0, 8'h00, 1'b1, 56'h0);
            @(negedge clk);
            chk($sformatf("drain%0d_req", k), {63'h0, bus.mem_req}, 64'h1);
            chk($sformatf("drain%0d_paddr", k), {8'h0, bus.mem_paddr}, {8'h0, exp_pa});
            chk($sformatf("drain%0d_be", k), {56'h0, bus.mem_be}, {56'h0, exp_be});
            chk($sformatf("drain%0d_data", k), bus.mem_data, exp_d);
            next_cycle();
        end
        drive(1'b0, 56'h0, 64'h0, 8'h00, 1'b0, 56'h0);
        @(negedge clk);
        chk("drained_empty", {63'h0, bus.empty}, 64'h1);
        next_cycle();

        // ---- merging disabled, then reset with entries pending ----
        drive2(1'b1, 56'h4000, 64'h01, 8'h01, 1'b0, 56'h5000);
        next_cycle();
        drive2(1'b1, 56'h4000, 64'h200, 8'h02, 1'b0, 56'h5000);
        next_cycle();
        drive2(1'b1, 56'h5000, 64'h3, 8'h01, 1'b0, 56'h5000);
        next_cycle();
        drive2(1'b1, 56'h6000, 64'h4, 8'h01, 1'b0, 56'h5000);
        next_cycle();
        drive2(1'b0, 56'h0, 64'h0, 8'h00, 1'b1, 56'h5000);
        @(negedge clk);
        chk("nm_first_paddr", {8'h0, bus2.mem_paddr}, 64'h4000);
        chk("nm_first_be", {56'h0, bus2.mem_be}, 64'h01);
        next_cycle();
        drive2(1'b0, 56'h0, 64'h0, 8'h00, 1'b0, 56'h5000);
        @(negedge clk);
        chk("nm_second_paddr", {8'h0, bus2.mem_paddr}, 64'h4000);
        chk("nm_second_be", {56'h0, bus2.mem_be}, 64'h02);
        chk("nm_ldhit", {63'h0, bus2.ld_hit}, 64'h1);
        rst2 = 1'b1;
        #1;
        chk("nm_rst_empty", {63'h0, bus2.empty}, 64'h1);
        chk("nm_rst_req", {63'h0, bus2.mem_req}, 64'h0);
        chk("nm_rst_ldhit", {63'h0, bus2.ld_hit}, 64'h0);
        chk("nm_rst_full", {63'h0, bus2.full}, 64'h0);
        next_cycle();
        rst2 = 1'b0;
        @(negedge clk);
        chk("nm_post_rdy", {63'h0, bus2.st_ready}, 64'h1);
        chk("nm_post_empty", {63'h0, bus2.empty}, 64'h1);
        next_cycle();

        // ---- randomized traffic against queue model ----
        rst = 1'b1;
        drive(1'b0, 56'h0, 64'h0, 8'h00, 1'b0, 56'h0);
        next_cycle();
        rst = 1'b0;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            logic        sv, gnt, e_req, e_rdy, e_ld, merge;
            logic [55:0] pa, la;
            logic [63:0] d, m;
            logic [7:0]  be;
            logic [52:0] stag;
            int          midx;
            sv  = ($urandom_range(0, 3) != 0);
            pa  = 56'h8000 + 56'($urandom_range(0, 5) * 8) + 56'($urandom_range(0, 7));
            d   = {$urandom, $urandom};
            be  = 8'($urandom_range(0, 255));
            gnt = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            la  = 56'h8000 + 56'($urandom_range(0, 7) * 8);
            drive(sv, pa, d, be, gnt, la);

            stag  = pa[55:3];
            e_req = (mq.size() != 0);
            midx  = -1;
            e_ld  = 1'b0;
            foreach (mq[k]) begin
                if (mq[k].tag == stag) midx = k;
                if (mq[k].tag == la[55:3]) e_ld = 1'b1;
            end
            merge = sv && (midx > 0);
            e_rdy = merge || (mq.size() < 8);

            @(negedge clk);
            chk("rnd_rdy", {63'h0, bus.st_ready}, {63'h0, e_rdy});
            chk("rnd_req", {63'h0, bus.mem_req}, {63'h0, e_req});
            chk("rnd_ldhit", {63'h0, bus.ld_hit}, {63'h0, e_ld});
            chk("rnd_empty", {63'h0, bus.empty}, {63'h0, (mq.size() == 0)});
            chk("rnd_full", {63'h0, bus.full}, {63'h0, (mq.size() == 8)});
            if (e_req) begin
                m = be_mask(mq[0].be);
                chk("rnd_paddr", {8'h0, bus.mem_paddr}, {8'h0, mq[0].tag, 3'b000});
                chk("rnd_be", {56'h0, bus.mem_be}, {56'h0, mq[0].be});
                chk("rnd_data", bus.mem_data & m, mq[0].data & m);
            end

            if (sv && e_rdy) begin
                if (merge) begin
                    m = be_mask(be);
                    mq[midx].data = (mq[midx].data & ~m) | (d & m);
                    mq[midx].be   = mq[midx].be | be;
                end else begin
                    mq.push_back('{tag: stag, data: d, be: be});
                end
            end
            if (gnt && e_req) void'(mq.pop_front());
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
